lfsr_random_source: RTL

- Synthesizable stand-in for the `$random` / `$dist_uniform` system functions.
- Produces pseudo-random words from a Galois LFSR, optionally reduced to a range [lo, hi].
- Delivers each word over a valid/ready handshake to the downstream consumer stage, which would otherwise call the system function.
- Sits directly upstream of that consumer; the consumer takes one word per transfer.

---
 rtl/lfsr_random_source.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lfsr_random_source.sv
// lfsr_random_source
// Synthesizable pseudo-random word source built on a Galois LFSR, delivering
// one word per valid/ready transfer to a downstream consumer.
// Optional build macro: LFSR_RANDOM_SOURCE_RANGE_EN
//   defined   -> words are reduced to [i_lo, i_hi] by rejection sampling
//   undefined -> words are the raw LFSR state; i_lo/i_hi are ignored
module lfsr_random_source #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] TAPS      = 32'h8020_0003,
  parameter logic [WIDTH-1:0] SEED      = 32'h0000_0001,
  parameter int               MAX_TRIES = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [15:0]      o_count
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_data;
  logic [15:0]      r_count;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_seed_val;
  logic             w_accept;
  logic             w_fill;
  logic             w_xfer;

  // Galois step: shift right, fold the taps back in when a one falls out.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  assign w_fill     = (r_state == S_FILL);
  assign w_xfer     = (r_state == S_HOLD) && i_ready;
  // A zero seed would lock the LFSR, so it falls back to the default seed.
  assign w_seed_val = (i_seed == '0) ? SEED : i_seed;

`ifdef LFSR_RANDOM_SOURCE_RANGE_EN
  localparam int             TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  logic [TRY_W-1:0] r_tries;
  logic [WIDTH:0]   w_span;
  logic [WIDTH:0]   w_mask;
  logic [WIDTH:0]   w_cand;
  logic [WIDTH:0]   w_forced;
  logic [WIDTH:0]   w_sel;
  logic             w_in_range;
  logic             w_unused_top;

  // Smear the highest set bit downwards: yields 2^clog2(v+1)-1.
  function automatic logic [WIDTH:0] smear(input logic [WIDTH:0] v);
    logic [WIDTH:0] m;
    m = v;
    for (int k = 1; k <= WIDTH; k = k * 2) begin
      m = m | (m >> k);
    end
    return m;
  endfunction

  // Range reduction: mask the LFSR to the next power of two above span,
  // reject out-of-range candidates until the try budget runs out.
  always_comb begin
    w_span     = (i_hi < i_lo) ? '0 : {1'b0, i_hi - i_lo};
    w_mask     = smear(w_span);
    w_cand     = {1'b0, r_lfsr} & w_mask;
    // cand < 2*(span+1), so subtracting span+1 always lands inside the range.
    w_forced   = w_cand - (w_span + 1'b1);
    w_in_range = (w_cand <= w_span);
    w_accept   = w_in_range || (r_tries == TRY_LAST);
    w_sel      = w_in_range ? w_cand : w_forced;
    w_result   = i_lo + w_sel[WIDTH-1:0];
  end

  assign w_unused_top = w_forced[WIDTH] ^ w_sel[WIDTH];

  // Try counter: counts rejected draws, cleared on accept or reseed.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_seed_load) begin
      r_tries <= '0;
    end else if (w_fill) begin
      r_tries <= w_accept ? '0 : r_tries + 1'b1;
    end
  end
`else
  logic w_unused_range;

  // Without range reduction every draw is accepted as the raw LFSR value.
  always_comb begin
    w_accept = 1'b1;
    w_result = r_lfsr;
  end

  assign w_unused_range = ^{i_lo, i_hi};
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: draw until accepted, hold until consumed; reseed restarts drawing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_accept) w_state_nxt = S_HOLD;
      S_HOLD:  if (i_ready)  w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
    if (i_seed_load) begin
      w_state_nxt = S_FILL;
    end
  end

  // LFSR advances only while drawing; frozen while a word is presented.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else if (i_seed_load) begin
      r_lfsr <= w_seed_val;
    end else if (w_fill) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  // Output word is captured on the accepting draw and held until consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (w_fill && w_accept && !i_seed_load) begin
      r_data <= w_result;
    end
  end

  // Transfer counter; a transfer coinciding with a reseed still counts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (w_xfer) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_valid = (r_state == S_HOLD);
  assign o_data  = r_data;
  assign o_count = r_count;

endmodule
